// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and helpers for the seven-segment display path.
//   SEP_NIBBLE        : nibble value used as a separator in packed time words
//   SEG_0..SEG_9      : segment codes {a,b,c,d,e,f,g,dp}, active-high
//   SEG_DASH/BLANK    : separator dash and all-off codes
//   nib2seg()         : nibble -> segment code (A..E blank, F dash, dp off)
// -----------------------------------------------------------------------------
package display_pkg;

    localparam logic [3:0] SEP_NIBBLE = 4'hF;

    localparam logic [7:0] SEG_0     = 8'hFC;
    localparam logic [7:0] SEG_1     = 8'h60;
    localparam logic [7:0] SEG_2     = 8'hDA;
    localparam logic [7:0] SEG_3     = 8'hF2;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'hB6;
    localparam logic [7:0] SEG_6     = 8'hBE;
    localparam logic [7:0] SEG_7     = 8'hE0;
    localparam logic [7:0] SEG_8     = 8'hFE;
    localparam logic [7:0] SEG_9     = 8'hF6;
    localparam logic [7:0] SEG_DASH  = 8'h02;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] nib2seg(input logic [3:0] nib);
        logic [7:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            SEP_NIBBLE: seg = SEG_DASH;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg_scan_driver_if
// Bus between the time/mode blocks and the scan driver.
//   en, time_data, blink_mask           : driven by master, consumed by driver
//   digit1, digit2, tube_sel, frame_done: driven by the scan driver
// -----------------------------------------------------------------------------
interface seg_scan_driver_if;
    logic        en;
    logic [31:0] time_data;
    logic [7:0]  blink_mask;
    logic [7:0]  digit1;
    logic [7:0]  digit2;
    logic [7:0]  tube_sel;
    logic        frame_done;

    modport master (
        output en, time_data, blink_mask,
        input  digit1, digit2, tube_sel, frame_done
    );

    modport slave (
        input  en, time_data, blink_mask,
        output digit1, digit2, tube_sel, frame_done
    );
endinterface

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running divider: counts 0..DIV-1 and wraps; o_tick is high on DIV-1.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset (counter -> 0)
//   o_tick : one-cycle strobe every DIV cycles
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV = 100000
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;
    logic         w_tick;

    assign w_tick = (r_cnt == W'(DIV - 1));
    assign o_tick = w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst)       r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Eight-tube seven-segment scan driver with double-buffered frames and
// per-tube blinking.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg_scan_driver_if
//              en/time_data/blink_mask in, digit1/digit2/tube_sel/frame_done out
// -----------------------------------------------------------------------------
module seg_scan_driver
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_scan_driver_if.slave     bus
);
    logic        w_tick;
    logic        w_frame_end;
    logic        w_load;
    logic [2:0]  w_tube;
    logic [3:0]  w_nib;
    logic [7:0]  w_seg;

    logic [2:0]  r_phase;
    logic [31:0] r_shadow_data;
    logic [7:0]  r_shadow_mask;
    logic [7:0]  r_frame_cnt;
    logic        r_blink_phase;
    logic        r_load_pending;
    logic [7:0]  r_digit1;
    logic [7:0]  r_digit2;
    logic [7:0]  r_tube_sel;
    logic        r_frame_done;

    scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
        .i_clk  (clk),
        .i_rst  (rst),
        .o_tick (w_tick)
    );

    assign w_frame_end = w_tick && (r_phase == 3'd7);
    assign w_load      = w_frame_end || r_load_pending;

    // Scan runs left to right: phase 0 lights tube 7.
    assign w_tube = 3'd7 - r_phase;
    assign w_nib  = r_shadow_data[{w_tube, 2'b00} +: 4];
    assign w_seg  = (r_shadow_mask[w_tube] && r_blink_phase) ? SEG_BLANK : nib2seg(w_nib);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase        <= '0;
            r_shadow_data  <= '0;
            r_shadow_mask  <= '0;
            r_frame_cnt    <= '0;
            r_blink_phase  <= 1'b0;
            r_load_pending <= 1'b1;
            r_digit1       <= '0;
            r_digit2       <= '0;
            r_tube_sel     <= '0;
            r_frame_done   <= 1'b0;
        end else begin
            r_load_pending <= 1'b0;
            if (w_tick) r_phase <= r_phase + 3'd1;

            if (w_load) begin
                r_shadow_data <= bus.time_data;
                r_shadow_mask <= bus.blink_mask;
            end

            // Only completed frames advance the blink timer; the post-reset
            // load just primes the shadow, so every blink half-period is
            // exactly BLINK_FRAMES full frames.
            if (w_frame_end) begin
                if (r_frame_cnt == 8'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt   <= r_frame_cnt + 8'd1;
                end
            end

            r_frame_done <= w_load;

            // Enable only gates the output registers; the scan keeps running.
            r_digit1   <= (bus.en &&  w_tube[2]) ? w_seg : SEG_BLANK;
            r_digit2   <= (bus.en && !w_tube[2]) ? w_seg : SEG_BLANK;
            r_tube_sel <= bus.en ? (8'd1 << w_tube) : 8'd0;
        end
    end

    assign bus.digit1     = r_digit1;
    assign bus.digit2     = r_digit2;
    assign bus.tube_sel   = r_tube_sel;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with SCAN_DIV=4, BLINK_FRAMES=2.
// Cycle k counts samples after reset release (k=1 is the first-load cycle);
// tube phase p = ((k-1)/4)%8 and a new frame is latched when k==1 or k%32==0.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;
    localparam int SD = 4;
    localparam int BF = 2;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  sel;
        logic [7:0]  d1;
        logic [7:0]  d2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl [16];

    seg_scan_driver_if bus ();

    seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s k=%0d got %02h exp %02h", nm, k, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_d1"},  0, bus.digit1, 8'h00);
        chk({nm, "_d2"},  0, bus.digit2, 8'h00);
        chk({nm, "_sel"}, 0, bus.tube_sel, 8'h00);
        chk({nm, "_fd"},  0, {7'd0, bus.frame_done}, 8'h00);
    endtask

    // base selects the word in tbl; blank_on blanks tubes 3,2; en_on=0 zeros outputs
    task automatic chk_cycle(input string nm, input int k, input int base,
                             input bit blank_on, input bit en_on);
        int         p;
        logic [7:0] e1, e2, es, efd;
        p  = ((k - 1) / 4) % 8;
        e1 = tbl[base + p].d1;
        e2 = tbl[base + p].d2;
        es = tbl[base + p].sel;
        if (blank_on && (p == 4 || p == 5)) begin
            e1 = 8'h00;
            e2 = 8'h00;
        end
        if (!en_on) begin
            e1 = 8'h00;
            e2 = 8'h00;
            es = 8'h00;
        end
        efd = (k == 1 || (k % 32) == 0) ? 8'h01 : 8'h00;
        chk({nm, "_d1"},  k, bus.digit1, e1);
        chk({nm, "_d2"},  k, bus.digit2, e2);
        chk({nm, "_sel"}, k, bus.tube_sel, es);
        chk({nm, "_fd"},  k, {7'd0, bus.frame_done}, efd);
    endtask

    initial begin
        // word A: 0 0 F 1 | 2 F 5 9
        tbl[0]  = '{32'h00F12F59, 8'h80, 8'hFC, 8'h00};
        tbl[1]  = '{32'h00F12F59, 8'h40, 8'hFC, 8'h00};
        tbl[2]  = '{32'h00F12F59, 8'h20, 8'h02, 8'h00};
        tbl[3]  = '{32'h00F12F59, 8'h10, 8'h60, 8'h00};
        tbl[4]  = '{32'h00F12F59, 8'h08, 8'h00, 8'hDA};
        tbl[5]  = '{32'h00F12F59, 8'h04, 8'h00, 8'h02};
        tbl[6]  = '{32'h00F12F59, 8'h02, 8'h00, 8'hB6};
        tbl[7]  = '{32'h00F12F59, 8'h01, 8'h00, 8'hF6};
        // word B: A B C D | E 7 8 9 (A..E blank)
        tbl[8]  = '{32'hABCDE789, 8'h80, 8'h00, 8'h00};
        tbl[9]  = '{32'hABCDE789, 8'h40, 8'h00, 8'h00};
        tbl[10] = '{32'hABCDE789, 8'h20, 8'h00, 8'h00};
        tbl[11] = '{32'hABCDE789, 8'h10, 8'h00, 8'h00};
        tbl[12] = '{32'hABCDE789, 8'h08, 8'h00, 8'h00};
        tbl[13] = '{32'hABCDE789, 8'h04, 8'h00, 8'hE0};
        tbl[14] = '{32'hABCDE789, 8'h02, 8'h00, 8'hFE};
        tbl[15] = '{32'hABCDE789, 8'h01, 8'h00, 8'hF6};

        bus.en         = 1'b1;
        bus.time_data  = tbl[0].word;
        bus.blink_mask = 8'h00;

        // reset state
        rst = 1'b1;
        step();
        step();
        chk_idle("reset");

        // reset then scan, decode, and no tearing when data changes at tube 5
        rst = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            step();
            chk_cycle("scan", k, ((k - 1) / 32 == 3) ? 8 : 0, 1'b0, 1'b1);
            if (k == 74) bus.time_data = tbl[8].word;
        end

        // mid-frame reset while tube 4 is lit
        for (int k = 129; k <= 142; k++) step();
        chk("pre_rst_sel", 142, bus.tube_sel, 8'h10);
        rst = 1'b1;
        step();
        chk_idle("midrst");

        // restart with blinking on tubes 3,2: blanked in frames 2-3 only
        bus.time_data  = tbl[0].word;
        bus.blink_mask = 8'h0C;
        rst = 1'b0;
        for (int k = 1; k <= 192; k++) begin
            step();
            chk_cycle("blink", k, 0, ((k - 1) / 32 == 2 || (k - 1) / 32 == 3), 1'b1);
            if (k == 180) bus.blink_mask = 8'h00;
        end

        // enable dropped for 10 cycles mid-tube-6; scan keeps running underneath
        for (int k = 193; k <= 224; k++) begin
            step();
            chk_cycle("enable", k, 0, 1'b0, !(k >= 199 && k <= 208));
            if (k == 198) bus.en = 1'b0;
            if (k == 208) bus.en = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
